neuron_layer_seq: RTL and testbench

//  Time-multiplexes one 9-input binary neuron datapath across NUM_NEURONS neurons to form one layer.

---
 rtl/neuron_layer_seq.sv | 97 +++++++++
 tb/tb_neuron_layer_seq.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/neuron_layer_seq.sv
// One 9-input binary neuron time-multiplexed over NUM_NEURONS weight words.
// A start latches x and walks the neurons one per cycle; done pulses when predict_vec is complete.
module neuron_eval (
  input  logic [79:0] wt,
  input  logic [8:0]  x,
  output logic        pred
);
  logic [7:0] sum;

  // Modulo-256 accumulate; the sign bit of the wrapped sum decides the output.
  always_comb begin
    sum = wt[7:0];
    for (int k = 0; k < 9; k++)
      if (x[k]) sum = sum + wt[8*k+8 +: 8];
  end

  assign pred = ~sum[7];
endmodule

module neuron_layer_seq #(
  parameter int NUM_NEURONS = 8,
  parameter int AW          = $clog2(NUM_NEURONS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [79:0]            wr_data,
  output logic                   wr_err,
  input  logic                   start,
  input  logic [8:0]             x_in,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_NEURONS-1:0] predict_vec
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  localparam logic [AW-1:0] LAST = AW'(NUM_NEURONS - 1);

  state_t        state;
  logic [AW-1:0] idx;
  logic [8:0]    x_q;
  logic [79:0]   wt [NUM_NEURONS];
  logic          addr_ok;
  logic          pred;

  assign addr_ok = (32'(wr_addr) < NUM_NEURONS);

  neuron_eval u_eval (
    .wt   (wt[idx]),
    .x    (x_q),
    .pred (pred)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      x_q         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      wr_err      <= 1'b0;
      predict_vec <= '0;
      for (int n = 0; n < NUM_NEURONS; n++) wt[n] <= '0;
    end else begin
      done   <= 1'b0;
      // Writes are only safe while the datapath is not reading the file.
      wr_err <= wr_en && ((state != IDLE) || !addr_ok);
      if (wr_en && (state == IDLE) && addr_ok) wt[wr_addr] <= wr_data;

      case (state)
        IDLE: begin
          if (start) begin
            x_q   <= x_in;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          predict_vec[idx] <= pred;
          if (idx == LAST) begin
            busy  <= 1'b0;
            state <= FIN;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        FIN: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_neuron_layer_seq.sv
// Directed bench for neuron_layer_seq with six neurons, so out-of-range write addresses exist.
`timescale 1ns/1ps
module tb_neuron_layer_seq;
  localparam int N  = 6;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [79:0]   wr_data = '0;
  logic          wr_err;
  logic          start = 1'b0;
  logic [8:0]    x_in = '0;
  logic          busy;
  logic          done;
  logic [N-1:0]  predict_vec;

  int total = 0;
  int bad   = 0;

  neuron_layer_seq #(.NUM_NEURONS(N), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_err(wr_err), .start(start), .x_in(x_in), .busy(busy), .done(done),
    .predict_vec(predict_vec)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Single-cycle write; wr_err is checked one edge later.
  task automatic write_w(input logic [AW-1:0] a, input logic [79:0] d, input logic exp_err,
                         input string tag);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
    check(tag, 32'(wr_err), 32'(exp_err));
  endtask

  // Start on the next edge T and wait for done (bounded); done must be seen after edge T+N+1.
  task automatic do_run(input logic [8:0] x, input logic [N-1:0] exp, input logic with_wr,
                        input logic [AW-1:0] a, input logic [79:0] d, input string tag);
    int c;
    @(negedge clk);
    start = 1'b1; x_in = x;
    wr_en = with_wr; wr_addr = a; wr_data = d;
    tick();
    start = 1'b0; wr_en = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    c = 0;
    while (!done && c < 20) begin tick(); c++; end
    check({tag, "_lat"}, 32'(c), 32'(N + 1));
    check({tag, "_busy_fin"}, 32'(busy), 32'd0);
    check({tag, "_vec"}, 32'(predict_vec), 32'(exp));
    tick();
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int c;
    #12 rst_n = 1'b1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wr_err", 32'(wr_err), 32'd0);
    check("rst_vec", 32'(predict_vec), 32'd0);

    // 1: zero weights -> sum 0 -> all ones
    do_run(9'h1FF, 6'h3F, 1'b0, '0, '0, "t1");

    // 2: neuron 0 bias 0x80
    write_w(3'd0, 80'h80, 1'b0, "t2_wr");
    do_run(9'h000, 6'h3E, 1'b0, '0, '0, "t2");

    // 3: neuron 1 bias 0x7F, w0=0x01 wraps to 0x80
    write_w(3'd1, 80'h017F, 1'b0, "t3_wr");
    // 4: neuron 2 all weights 0x10, bias 0xB0
    write_w(3'd2, {{9{8'h10}}, 8'hB0}, 1'b0, "t4_wr");
    do_run(9'h001, 6'h38, 1'b0, '0, '0, "t3a");
    do_run(9'h000, 6'h3A, 1'b0, '0, '0, "t3b");
    do_run(9'h1FF, 6'h3C, 1'b0, '0, '0, "t4a");
    do_run(9'h00F, 6'h38, 1'b0, '0, '0, "t4b");

    // out-of-range address rejected in IDLE, in-range accepted
    write_w(3'd6, 80'h80, 1'b1, "oor6");
    write_w(3'd7, 80'h80, 1'b1, "oor7");
    write_w(3'd5, 80'h00, 1'b0, "inrange5");

    // 5: write + second start during RUN are rejected, only one done
    @(negedge clk);
    start = 1'b1; x_in = 9'h000;
    tick();
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; x_in = 9'h1FF;
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 80'h80;
    tick();
    start = 1'b0; wr_en = 1'b0;
    check("t5_wr_err", 32'(wr_err), 32'd1);
    tick();
    check("t5_wr_err_pulse", 32'(wr_err), 32'd0);
    c = 2;
    while (!done && c < 20) begin tick(); c++; end
    check("t5_lat", 32'(c), 32'(N + 1));
    check("t5_vec", 32'(predict_vec), 32'h3A);
    c = 0;
    repeat (N + 3) begin tick(); if (done || busy) c++; end
    check("t5_single_done", 32'(c), 32'd0);
    do_run(9'h000, 6'h3A, 1'b0, '0, '0, "t5_wt_kept");

    // write and start in the same cycle: the write lands first
    do_run(9'h000, 6'h2A, 1'b1, 3'd4, 80'h80, "same_cyc");

    // 6: asynchronous reset mid-run
    @(negedge clk);
    start = 1'b1; x_in = 9'h1FF;
    tick();
    start = 1'b0;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_done", 32'(done), 32'd0);
    check("t6_vec", 32'(predict_vec), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_run(9'h1FF, 6'h3F, 1'b0, '0, '0, "t6_rerun");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
